// File: rtl/cpu_state_sequencer.sv
// Multicycle CPU state sequencer: HALT/FETCH/DECODE/EXEC1/EXEC2 with Avalon stalls,
// PC write strobe and retired count. Optional macro WAIT_TIMEOUT_EN adds a stall watchdog.
module cpu_state_sequencer #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 256
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [5:0]       opcode,
   input  logic             read_req,
   input  logic             write_req,
   input  logic             waitrequest,
   input  logic             halt_req,
   output logic [3:0]       state,
   output logic             fetch_read,
   output logic             pc_write,
   output logic             active,
   output logic [CNT_W-1:0] retired,
   output logic             illegal_state,
   output logic             timeout_err
);

   localparam logic [3:0] S_HALT   = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd2;
   localparam logic [3:0] S_EXEC1  = 4'd3;
   localparam logic [3:0] S_EXEC2  = 4'd4;

   logic [3:0] state_nxt;
   logic       stall, short_op, retire, illegal, tmo;

   assign short_op = (opcode == 6'b000100) || (opcode == 6'b000010);

   // waitrequest only matters while the matching request is active
   always_comb begin
      stall = 1'b0;
      case (state)
         S_FETCH: stall = waitrequest;
         S_EXEC1: stall = read_req & waitrequest;
         S_EXEC2: stall = write_req & waitrequest;
         default: stall = 1'b0;
      endcase
   end

   assign retire = !stall && (((state == S_EXEC1) && short_op) || (state == S_EXEC2));

`ifdef WAIT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] wait_cnt;

   // wait_cnt holds prior consecutive stalls; this cycle is stall number wait_cnt+1
   assign tmo = stall && (wait_cnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (stall && !tmo) wait_cnt <= wait_cnt + 1'b1;
         else               wait_cnt <= '0;
         if (tmo) timeout_err <= 1'b1;
      end
   end
`else
   assign tmo         = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      illegal   = 1'b0;
      case (state)
         S_HALT:   if (start) state_nxt = S_FETCH;
         S_FETCH:  if (!stall) state_nxt = S_DECODE;
         S_DECODE: state_nxt = S_EXEC1;
         S_EXEC1:  if (!stall) state_nxt = short_op ? (halt_req ? S_HALT : S_FETCH) : S_EXEC2;
         S_EXEC2:  if (!stall) state_nxt = halt_req ? S_HALT : S_FETCH;
         default: begin
            state_nxt = S_HALT;
            illegal   = 1'b1;
         end
      endcase
      if (tmo) state_nxt = S_HALT;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_HALT;
         retired       <= '0;
         illegal_state <= 1'b0;
      end else begin
         state <= state_nxt;
         if (retire)  retired       <= retired + 1'b1;
         if (illegal) illegal_state <= 1'b1;
      end
   end

   // a timeout only fires on a stalled cycle, which can never be a retire cycle
   assign pc_write   = retire;
   assign fetch_read = (state == S_FETCH);
   assign active     = (state != S_HALT);

endmodule
